// File: rtl/aca_if.sv
// Handshake and data bundle for the speculative-adder recovery stage.
// The master drives operands and result acceptance; the slave is the adder.
interface aca_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             err_flag;
    logic [15:0]      err_count;

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, Sum, Cout, err_flag, err_count
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, Sum, Cout, err_flag, err_count
    );
endinterface

// File: rtl/aca_recovery.sv
// Almost-correct adder with error detection and chunked sequential recovery.
// A windowed carry speculation is evaluated once; if any run of WINDOW
// propagates (starting at bit 1 or above) could hide a longer carry chain,
// the exact sum is rebuilt one WINDOW-wide chunk per cycle.
module aca_recovery #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    aca_if.slave  aca_s
);
    localparam int N  = WIDTH / WINDOW;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             flag_q, flag_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [15:0]      cnt_q, cnt_d;

    logic [WIDTH-1:0] p, g, spec_sum;
    logic [WIDTH:0]   spec_c;
    logic             spec_err;
    logic [WINDOW:0]  chunk;

    // Speculative carries: exact prefix for the low bits, WINDOW-deep look-back above
    always_comb begin
        logic c;
        int   lo;
        c        = 1'b0;
        lo       = 0;
        p        = a_q ^ b_q;
        g        = a_q & b_q;
        spec_c   = '0;
        spec_c[0] = cin_q;
        for (int i = 1; i <= WIDTH; i++) begin
            c  = (i <= WINDOW) ? cin_q : 1'b0;
            lo = (i > WINDOW) ? i - WINDOW : 0;
            for (int j = 0; j < WIDTH; j++)
                if (j >= lo && j < i)
                    c = g[j] | (p[j] & c);
            spec_c[i] = c;
        end
        spec_sum = p ^ spec_c[WIDTH-1:0];
        // Conservative: a full-window propagate run means a carry may be lost
        spec_err = 1'b0;
        for (int j = 1; j <= WIDTH - WINDOW; j++)
            if (&p[j +: WINDOW])
                spec_err = 1'b1;
    end

    // One exact chunk addition per FIX cycle
    always_comb begin
        chunk = {1'b0, a_q[int'(k_q) * WINDOW +: WINDOW]}
              + {1'b0, b_q[int'(k_q) * WINDOW +: WINDOW]}
              + {{WINDOW{1'b0}}, carry_q};
    end

    // Control FSM and datapath next-state
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        flag_d  = flag_q;
        carry_d = carry_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (aca_s.in_valid) begin
                    a_d     = aca_s.A;
                    b_d     = aca_s.B;
                    cin_d   = aca_s.Cin;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (spec_err) begin
                    k_d     = '0;
                    carry_d = cin_q;
                    flag_d  = 1'b1;
                    state_d = S_FIX;
                end else begin
                    sum_d   = spec_sum;
                    cout_d  = spec_c[WIDTH];
                    flag_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_FIX: begin
                sum_d[int'(k_q) * WINDOW +: WINDOW] = chunk[WINDOW-1:0];
                carry_d = chunk[WINDOW];
                k_d     = k_q + 1'b1;
                if (k_q == KW'(N - 1)) begin
                    cout_d  = chunk[WINDOW];
                    k_d     = '0;
                    if (cnt_q != 16'hFFFF)
                        cnt_d = cnt_q + 16'd1;
                    state_d = S_DONE;
                end
            end
            default: begin
                if (aca_s.out_ready)
                    state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            flag_q  <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            flag_q  <= flag_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    assign aca_s.in_ready  = (state_q == S_IDLE);
    assign aca_s.out_valid = (state_q == S_DONE);
    assign aca_s.Sum       = sum_q;
    assign aca_s.Cout      = cout_q;
    assign aca_s.err_flag  = flag_q;
    assign aca_s.err_count = cnt_q;
endmodule

// File: doc/aca_recovery.md
# aca_recovery

Variable-latency error detection and recovery stage for the 8-bit almost-correct (speculative window) adder. Accepts an operand pair and carry-in over a valid/ready handshake and computes the window-speculative sum. If the speculation is unsafe, the stage sequentially recomputes the exact result one window-sized chunk per cycle. The delivered result is always exact; a flag reports whether recovery was needed. The block sits downstream of operand sources as the speculative adder's verify/correct end, and provides the exact-result path for accuracy/latency studies.

## Interface
- WIDTH, 8, operand width; must be a multiple of WINDOW
- WINDOW, 4, speculation window (carry look-back depth) and recovery chunk size; 2 ≤ WINDOW < WIDTH
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- Sum  output  WIDTH  exact sum, registered
- Cout  output  1  exact carry-out, registered
- err_flag  output  1  1 = speculation unsafe, recovery path taken for this result
- err_count  output  16  saturating count of recovered operations since reset

## Operation
- P[i] = A[i]^B[i]; G[i] = A[i]&B[i].
- Speculative carry into bit i (i = 1..WIDTH, with bit WIDTH being Cout):
  - i ≤ WINDOW: exact prefix over bits 0..i-1 including Cin.
  - i > WINDOW: prefix over bits i-WINDOW..i-1 only, carry-in forced to 0.
- Detection is conservative: err = 1 iff some j in [1, WIDTH-WINDOW] has P[j..j+WINDOW-1] all ones. When err = 0, the speculative result equals the exact result.
- FSM states:
  - IDLE: in_ready = 1. On in_valid & in_ready, register A, B, Cin and go to EVAL.
  - EVAL: compute speculative result and err.
    - err = 0: load Sum/Cout from the speculative result, err_flag = 0, go to DONE.
    - err = 1: clear chunk index k = 0, set running carry = Cin, err_flag = 1, go to FIX.
  - FIX: add chunk bits [k*WINDOW +: WINDOW] with the running carry. Write those Sum bits and update the running carry. k++. After chunk N-1 (N = WIDTH/WINDOW), write Cout = final carry, increment err_count (saturating at 0xFFFF), and go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- in_ready = (state == IDLE). The block is not pipelined: one operation is in flight at a time.
- Sum, Cout and err_flag are held stable from out_valid rise until the handshake completes, and remain held until the next EVAL/FIX write.
- Reset (rst_n low at an edge) from any state, including mid-FIX:
  - state → IDLE; in-flight operation discarded
  - out_valid = 0, Sum = 0, Cout = 0, err_flag = 0, err_count = 0, k = 0
  - in_ready reads 1 from the first cycle after reset is released
  - in_valid is ignored while rst_n is low

## Timing
- Cycle 0 = accept edge (in_valid & in_ready).
- No error: EVAL in cycle 1; out_valid high in cycle 2 (latency 2).
- Error: EVAL in cycle 1, FIX in cycles 2..N+1, out_valid high in cycle N+2. For WIDTH=8, WINDOW=4: latency 4.
- Output transfer occurs on the edge with out_valid & out_ready; IDLE (in_ready = 1) follows in the next cycle. Minimum initiation interval is 3 cycles.
- err_count updates on the same edge as the transition FIX → DONE.

## Test plan
- A=0x12, B=0x34, Cin=0 → Sum=0x46, Cout=0, err_flag=0, out_valid 2 cycles after accept, err_count unchanged.
- A=0x7F, B=0x01, Cin=0 (P[1..6] ones) → err path; Sum=0x80, Cout=0, err_flag=1, out_valid 4 cycles after accept, err_count +1.
- A=0xFF, B=0x01, Cin=0 → Sum=0x00, Cout=1, err_flag=1, latency 4; A=0x0F, B=0xF0, Cin=1 → Sum=0x00, Cout=1, err_flag=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid with in_valid=1 and new operands → Sum/Cout/err_flag stable, in_ready=0, new operands not accepted until 1 cycle after the output handshake.
- Reset mid-FIX (rst_n=0 one cycle during the first FIX cycle of A=0x7F, B=0x01) → next cycle out_valid=0, Sum=0, Cout=0, err_count=0, in_ready=1 after release; a following A=0x01, B=0x01 yields Sum=0x02, err_flag=0.
- Random sweep: 10k random A/B/Cin with random out_ready stalls → Sum/Cout always equal A+B+Cin; err_flag matches the run-of-WINDOW-propagates rule; err_count equals the number of err_flag=1 results.
